mp_addsub_seq: RTL and testbench
================================

Name: mp_addsub_seq

Overview:
Multi-precision add/subtract sequencer for the ALU. Breaks an NBYTES-wide add or subtract into byte-serial operations, one byte per cycle through the team's 8-bit `adder`. Chains the carry/borrow between bytes and assembles the full-width result and status flags. Sits directly upstream of `adder`, driving `add1`, `add2`, `ci`, `flag` and `flip`, and also consumes its `sum` and `co`.

Parameters:
NBYTES, 4, operand width in bytes (>=2); W = 8*NBYTES.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request new operation; accepted only when busy==0
op_sub  input  1  0 = A+B, 1 = A-B; sampled with start
opa  input  W  operand A; sampled with start
opb  input  W  operand B; sampled with start
busy  output  1  high while bytes are being processed
done  output  1  one-cycle pulse; result and flags valid from this cycle
result  output  W  registered result; held until next accepted start
carry_out  output  1  add: carry out of MSB; sub: borrow (1 iff opa<opb unsigned)
zero  output  1  result==0
overflow  output  1  signed two's-complement overflow

Behaviour:
- Reset: async. All outputs and internal registers cleared; state=IDLE. Applies mid-operation too: the operation is abandoned and no done pulse is produced.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, byte index idx counts 0..NBYTES-1.
  - DONE: busy=0, done=1.
- Transitions:
  - IDLE, start=1 -> RUN. Latch opa, opb, op_sub; idx=0; carry reg=0.
  - RUN, idx<NBYTES-1 -> RUN, idx+1.
  - RUN, idx==NBYTES-1 -> DONE.
  - DONE, start=1 -> RUN (back-to-back accept, same latching as IDLE).
  - DONE, start=0 -> IDLE.
- start while busy=1 is ignored; the latched operands are unchanged.
- Adder drive in RUN:
  - add1 = A byte idx; add2 = B byte idx; flip = op_sub.
  - flag = (idx!=0); ci = carry reg.
- Carry chaining. `adder` inverts the effective carry-in when flip=1, so:
  - add: carry reg <= co.
  - sub: carry reg <= ~co, i.e. borrow is stored.
  - Byte 0 of a sub therefore computes a+~b+1; later bytes compute a+~b+~borrow.
- result byte idx <= sum at the end of each RUN cycle. Unwritten bytes keep their previous values until overwritten.
- Flags registered on the final RUN cycle, valid in DONE:
  - carry_out = add ? co : ~co.
  - zero = (full result incl. final byte == 0).
  - overflow = (A[W-1] == Beff[W-1]) && (R[W-1] != A[W-1]), where Beff = op_sub ? ~B : B.
- Latency: start accepted at edge T0. RUN occupies cycles T1..T_NBYTES. done is high in cycle T_(NBYTES+1). Throughput is one operation per NBYTES+1 cycles.
- result and flags are stable from done until the next accepted start. They are not cleared at that start; they are overwritten byte-wise during RUN.

Decomposition:
- Package alu_pkg:
  - state enum {IDLE, RUN, DONE}.
  - op encoding constants OP_ADD=0, OP_SUB=1.
  - index width localparam $clog2(NBYTES).
- Sub-module: one instance of the existing `adder`. All sequencing, operand byte selection, carry register and flag logic live in mp_addsub_seq.

Test Plan:
- NBYTES=4, add 0x000000FF+0x00000001 -> result 0x00000100, carry_out 0, zero 0, overflow 0; done exactly 5 cycles after the start edge.
- Add 0xFFFFFFFF+0x00000001 -> result 0x00000000, carry_out 1, zero 1, overflow 0.
- Sub 0x00000100-0x00000001 -> result 0x000000FF, carry_out (borrow) 0; sub 0x00000000-0x00000001 -> 0xFFFFFFFF, borrow 1.
- Overflow: add 0x7FFFFFFF+0x00000001 -> 0x80000000, overflow 1; sub 0x80000000-0x00000001 -> 0x7FFFFFFF, overflow 1.
- Pulse start with new operands during RUN -> ignored, first result unchanged. Assert start during DONE -> next op starts the following cycle with no IDLE gap.
- Assert reset mid-RUN (idx=2) -> busy, done, result, flags are 0 immediately (asynchronously). No done pulse follows; the next start completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer.
// Provides the sequencer state encoding, the add/sub opcode values, default
// sizing constants and a signed-overflow helper used when building flags.
package alu_pkg;

   // Sequencer states: idle, byte-serial processing, completion pulse.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Operation select values carried on op_sub.
   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Default operand size and the matching byte-index width.
   localparam int DEF_NBYTES = 4;
   localparam int DEF_IDX_W  = $clog2(DEF_NBYTES);

   // Two's-complement overflow: both addends share a sign and the result
   // sign differs from it. b_msb must already reflect any subtract inversion.
   function automatic logic signed_overflow(input logic a_msb,
                                            input logic b_msb,
                                            input logic r_msb);
      return (a_msb == b_msb) && (r_msb != a_msb);
   endfunction

endpackage

// File: rtl/mp_addsub_seq_adder.sv
// 8-bit ALU adder slice driven by the multi-precision sequencer.
// Ports:
//   add1, add2 : byte operands
//   ci         : carry/borrow from the previous byte
//   flag       : 1 = use ci (chained byte), 0 = first byte, no incoming carry
//   flip       : 1 = subtract; add2 is inverted and the effective carry-in
//                is inverted as well, so a first byte computes add1+~add2+1
//   sum, co    : byte result and raw carry out of bit 7
module adder (
   input  logic [7:0] add1,
   input  logic [7:0] add2,
   input  logic       ci,
   input  logic       flag,
   input  logic       flip,
   output logic [7:0] sum,
   output logic       co
);

   logic [7:0] b_eff_s;
   logic       cin_s;
   logic [8:0] total_s;

   // Operand conditioning and 9-bit add producing sum and carry.
   always_comb begin
      b_eff_s = flip ? ~add2 : add2;
      cin_s   = (flag & ci) ^ flip;
      total_s = {1'b0, add1} + {1'b0, b_eff_s} + {8'd0, cin_s};
   end

   assign sum = total_s[7:0];
   assign co  = total_s[8];

endmodule

// File: rtl/mp_addsub_seq.sv
// Multi-precision add/subtract sequencer.
// Splits an NBYTES-wide add or subtract into one byte per cycle through the
// 8-bit adder slice, chaining carry (add) or borrow (sub) between bytes, and
// assembles the full-width result plus carry/zero/overflow flags.
// Ports:
//   clk, reset            : rising-edge clock, async active-high reset
//   start, op_sub         : request and operation (0 add, 1 sub), idle/done only
//   opa, opb              : W-bit operands, latched on accepted start
//   busy                  : high while bytes are processed
//   done                  : one-cycle pulse, result and flags valid from here
//   result                : W-bit result, held until overwritten by next op
//   carry_out             : add carry out / sub borrow (opa < opb unsigned)
//   zero, overflow        : result == 0 / signed overflow
module mp_addsub_seq
   import alu_pkg::*;
#(
   parameter int NBYTES = DEF_NBYTES
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                op_sub,
   input  logic [8*NBYTES-1:0] opa,
   input  logic [8*NBYTES-1:0] opb,
   output logic                busy,
   output logic                done,
   output logic [8*NBYTES-1:0] result,
   output logic                carry_out,
   output logic                zero,
   output logic                overflow
);

   localparam int W     = 8 * NBYTES;
   localparam int IDX_W = $clog2(NBYTES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

   state_t           state_r;
   logic [IDX_W-1:0] idx_r;
   logic [W-1:0]     a_r;
   logic [W-1:0]     b_r;
   logic             sub_r;
   logic             carry_r;

   logic [7:0]       add1_s;
   logic [7:0]       add2_s;
   logic             ci_s;
   logic             flag_s;
   logic             flip_s;
   logic [7:0]       sum_s;
   logic             co_s;

   logic [7:0]       a_byte_s;
   logic [7:0]       b_byte_s;
   logic [W-1:0]     res_next_s;
   logic             chain_s;

   // Select the current operand bytes and merge the adder sum into the result.
   always_comb begin
      a_byte_s   = 8'd0;
      b_byte_s   = 8'd0;
      res_next_s = result;
      for (int i = 0; i < NBYTES; i++) begin
         if (idx_r == IDX_W'(i)) begin
            a_byte_s                = a_r[8*i +: 8];
            b_byte_s                = b_r[8*i +: 8];
            res_next_s[8*i +: 8]    = sum_s;
         end else begin
            res_next_s[8*i +: 8]    = result[8*i +: 8];
         end
      end
   end

   // Adder drive: only meaningful during RUN, quiet otherwise.
   always_comb begin
      if (state_r == RUN) begin
         add1_s = a_byte_s;
         add2_s = b_byte_s;
         flip_s = sub_r;
         flag_s = (idx_r != {IDX_W{1'b0}});
         ci_s   = carry_r;
      end else begin
         add1_s = 8'd0;
         add2_s = 8'd0;
         flip_s = 1'b0;
         flag_s = 1'b0;
         ci_s   = 1'b0;
      end
   end

   // For subtract the stored chain bit is the borrow, the complement of co.
   assign chain_s = (sub_r == OP_SUB) ? ~co_s : co_s;

   adder u_adder (
      .add1 (add1_s),
      .add2 (add2_s),
      .ci   (ci_s),
      .flag (flag_s),
      .flip (flip_s),
      .sum  (sum_s),
      .co   (co_s)
   );

   // Sequencer FSM with registered busy/done, result and flag updates.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r   <= IDLE;
         idx_r     <= {IDX_W{1'b0}};
         a_r       <= {W{1'b0}};
         b_r       <= {W{1'b0}};
         sub_r     <= 1'b0;
         carry_r   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         result    <= {W{1'b0}};
         carry_out <= 1'b0;
         zero      <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         case (state_r)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  a_r     <= opa;
                  b_r     <= opb;
                  sub_r   <= op_sub;
                  idx_r   <= {IDX_W{1'b0}};
                  carry_r <= 1'b0;
                  busy    <= 1'b1;
                  state_r <= RUN;
               end else begin
                  busy    <= 1'b0;
                  state_r <= IDLE;
               end
            end
            RUN: begin
               result  <= res_next_s;
               carry_r <= chain_s;
               if (idx_r == LAST_IDX) begin
                  carry_out <= chain_s;
                  zero      <= (res_next_s == {W{1'b0}});
                  overflow  <= signed_overflow(a_r[W-1],
                                               (sub_r == OP_SUB) ? ~b_r[W-1] : b_r[W-1],
                                               sum_s[7]);
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state_r   <= DONE;
               end else begin
                  idx_r     <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
               end
            end
            default: begin
               busy    <= 1'b0;
               done    <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mp_addsub_seq.sv
// Self-checking bench for mp_addsub_seq (NBYTES=4): directed table, corner
// sequences and randomized operations against a plain-arithmetic model.
module tb_mp_addsub_seq;

   logic        clk;
   logic        reset;
   logic        start;
   logic        op_sub;
   logic [31:0] opa;
   logic [31:0] opb;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        carry_out;
   logic        zero;
   logic        overflow;

   int total;
   int bad;

   mp_addsub_seq #(.NBYTES(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .op_sub    (op_sub),
      .opa       (opa),
      .opb       (opb),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .carry_out (carry_out),
      .zero      (zero),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        sub;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      logic        c;
      logic        z;
      logic        v;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model from plain arithmetic on the full-width operands.
   task automatic model(input logic sub, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic c, output logic z, output logic v);
      longint sa, sb, sr;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (sub) begin
         r  = a - b;
         c  = (a < b);
         sr = sa - sb;
      end else begin
         r  = a + b;
         c  = ({1'b0, a} + {1'b0, b}) > 33'h0_FFFF_FFFF;
         sr = sa + sb;
      end
      z = (r == 32'd0);
      v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
   endtask

   // Present an op at a negedge, let it be accepted, then wait for done.
   task automatic launch(input logic sub, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start  = 1'b1;
      op_sub = sub;
      opa    = a;
      opb    = b;
   endtask

   task automatic wait_done(output int lat);
      @(posedge clk);
      #1;
      start = 1'b0;
      lat   = 0;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic check_op(input string name, input logic sub, input logic [31:0] a,
                           input logic [31:0] b, input int lat);
      logic [31:0] er;
      logic ec, ez, ev;
      model(sub, a, b, er, ec, ez, ev);
      chk({name, " latency"}, 64'(lat), 64'd5);
      chk({name, " result"}, 64'(result), 64'(er));
      chk({name, " carry"}, 64'(carry_out), 64'(ec));
      chk({name, " zero"}, 64'(zero), 64'(ez));
      chk({name, " overflow"}, 64'(overflow), 64'(ev));
   endtask

   initial begin
      int          lat;
      logic [31:0] r1;
      logic        c1, z1, v1;
      logic        saw_done;

      total  = 0;
      bad    = 0;
      reset  = 1'b1;
      start  = 1'b0;
      op_sub = 1'b0;
      opa    = 32'd0;
      opb    = 32'd0;

      vecs[0] = '{1'b0, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
      vecs[2] = '{1'b1, 32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b1};
      vecs[5] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1};
      vecs[6] = '{1'b1, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b1, 1'b0};

      repeat (2) @(negedge clk);
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset done", 64'(done), 64'd0);
      chk("reset result", 64'(result), 64'd0);
      chk("reset flags", 64'({carry_out, zero, overflow}), 64'd0);
      reset = 1'b0;

      // Directed table.
      for (int i = 0; i < 7; i++) begin
         launch(vecs[i].sub, vecs[i].a, vecs[i].b);
         wait_done(lat);
         chk($sformatf("vec%0d latency", i), 64'(lat), 64'd5);
         chk($sformatf("vec%0d result", i), 64'(result), 64'(vecs[i].r));
         chk($sformatf("vec%0d carry", i), 64'(carry_out), 64'(vecs[i].c));
         chk($sformatf("vec%0d zero", i), 64'(zero), 64'(vecs[i].z));
         chk($sformatf("vec%0d overflow", i), 64'(overflow), 64'(vecs[i].v));
         @(negedge clk);
         chk($sformatf("vec%0d done pulse width", i), 64'(done), 64'd0);
         chk($sformatf("vec%0d result held", i), 64'(result), 64'(vecs[i].r));
      end

      // Start during RUN is ignored.
      launch(1'b0, 32'h0102_0304, 32'h1010_1010);
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      chk("busy in run", 64'(busy), 64'd1);
      start  = 1'b1;
      op_sub = 1'b1;
      opa    = 32'hDEAD_BEEF;
      opb    = 32'h0BAD_F00D;
      @(negedge clk);
      start  = 1'b0;
      lat    = 2;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("ignored start latency", 64'(lat), 64'd5);
      chk("ignored start result", 64'(result), 64'h1112_1314);

      // Back-to-back: start asserted during DONE.
      launch(1'b0, 32'h0000_1111, 32'h0000_2222);
      wait_done(lat);
      chk("b2b first result", 64'(result), 64'h0000_3333);
      start  = 1'b1;
      op_sub = 1'b1;
      opa    = 32'h0000_5000;
      opb    = 32'h0000_0001;
      wait_done(lat);
      check_op("b2b second", 1'b1, 32'h0000_5000, 32'h0000_0001, lat);

      // Immediate busy after a DONE-cycle start (no IDLE gap).
      @(negedge clk);
      launch(1'b0, 32'h0000_0001, 32'h0000_0001);
      wait_done(lat);
      start = 1'b1;
      opa   = 32'h0000_0002;
      opb   = 32'h0000_0003;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("no idle gap busy", 64'(busy), 64'd1);
      lat = 0;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("no idle gap latency", 64'(lat), 64'd5);
      chk("no idle gap result", 64'(result), 64'd5);

      // Reset mid-RUN at byte index 2.
      @(negedge clk);
      launch(1'b0, 32'h1111_1111, 32'h2222_2222);
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("midreset busy", 64'(busy), 64'd0);
      chk("midreset done", 64'(done), 64'd0);
      chk("midreset result", 64'(result), 64'd0);
      chk("midreset flags", 64'({carry_out, zero, overflow}), 64'd0);
      @(negedge clk);
      reset    = 1'b0;
      saw_done = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      chk("no done after reset", 64'(saw_done), 64'd0);
      launch(1'b1, 32'h0000_0010, 32'h0000_0020);
      wait_done(lat);
      check_op("after reset", 1'b1, 32'h0000_0010, 32'h0000_0020, lat);

      // Randomized operations against the model.
      for (int k = 0; k < 60; k++) begin
         logic        s;
         logic [31:0] a, b;
         s = 1'($urandom_range(1, 0));
         a = $urandom;
         b = $urandom;
         if (k % 10 == 3) b = a;
         if (k % 10 == 7) a = 32'hFFFF_FFFF;
         launch(s, a, b);
         wait_done(lat);
         model(s, a, b, r1, c1, z1, v1);
         chk($sformatf("rand%0d latency", k), 64'(lat), 64'd5);
         chk($sformatf("rand%0d result", k), 64'(result), 64'(r1));
         chk($sformatf("rand%0d flags", k), 64'({carry_out, zero, overflow}),
             64'({c1, z1, v1}));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
